alu_exec_unit: RTL
==================

# alu_exec_unit

Parametrised execute-stage unit for the N-bit RISC-V integer core. It combines ALU control decode and a registered result datapath. RV32I-style ops (add, sub, logic, compare, shifts) complete in one cycle. Unsigned multiply and divide (MUL, MULHU, DIVU, REMU) run iteratively over WIDTH cycles behind a valid/ready handshake. It replaces the combinational decode-plus-ALU path when the M subset is enabled.

## Interface
- WIDTH, 32: datapath width in bits; must be ≥ 4 and a power of two.
- CLK input 1: single clock, rising edge.
- RST input 1: asynchronous, active-low reset.
- Flush input 1: synchronous abort of any in-flight operation.
- in_valid input 1: operation request.
- in_ready output 1: unit can accept a request this cycle.
- ALUOP input 2: main-decoder class (00 add, 01 sub, 10 funct-decoded, 11 add).
- funct3 input 3: instruction funct3.
- funct7_5 input 1: instruction bit 30 (sub/sra select).
- funct7_0 input 1: instruction bit 25 (M-extension select).
- OP input 1: 1 = R-type, 0 = I-type.
- SrcA input WIDTH: operand A.
- SrcB input WIDTH: operand B.
- Result output WIDTH: registered result.
- Zero output 1: Result == 0 (combinational from the Result register).
- out_valid output 1: one-cycle pulse, Result is valid.

## Operation
- Decode to a 4-bit ALUControl code. Inputs are sampled only on acceptance (in_valid & in_ready & !Flush).
- ALUOP 00 → ADD; 01 → SUB; 11 → ADD.
- ALUOP 10 with OP=1 and funct7_0=1, by funct3:
  - 000 MUL, 011 MULHU, 101 DIVU, 111 REMU.
  - Any other funct3 → ADD.
- ALUOP 10 otherwise, by funct3:
  - 000: SUB if OP & funct7_5, else ADD.
  - 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR.
  - 101: SRA if funct7_5, else SRL.
  - 110 OR; 111 AND.
- Shift amount = SrcB[log2(WIDTH)-1:0]. All arithmetic is modulo 2^WIDTH. SLT/SLTU produce 0 or 1, zero-extended.
- MUL returns the low WIDTH bits of the unsigned product. MULHU returns the high WIDTH bits.
- DIVU by zero returns all ones. REMU by zero returns SrcA.
- States:
  - IDLE: in_ready=1. Accepting a single-cycle op, or DIVU/REMU with SrcB=0, registers Result and pulses out_valid next cycle; state stays IDLE. Accepting MUL/MULHU → MUL_RUN. Accepting DIVU/REMU with SrcB≠0 → DIV_RUN.
  - MUL_RUN: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator. After WIDTH iterations, load Result, pulse out_valid, return to IDLE.
  - DIV_RUN: restoring division, one quotient bit per cycle. After WIDTH iterations, load quotient (DIVU) or remainder (REMU), pulse out_valid, return to IDLE.
- Flush: next state is IDLE, with no out_valid for the aborted op. Result holds its prior value. Flush has priority over a same-cycle request, which is not accepted.
- Reset (any time, including mid-iteration): state IDLE, Result=0 (so Zero=1), out_valid=0, iteration counter=0. in_ready=1 as soon as RST is released.

## Timing
- Single-cycle ops: accept on edge k → Result/out_valid valid after edge k+1. Back-to-back acceptance every cycle gives throughput 1/cycle.
- MUL/MULHU/DIVU/REMU (divisor ≠ 0): accept on edge k → out_valid after edge k+WIDTH+1.
  - in_ready=0 from after edge k until the cycle out_valid is high.
  - in_ready returns high in the out_valid cycle, so a new op can be accepted on that edge.
- Divide by zero: latency 1, same as single-cycle ops.
- out_valid is high for exactly one cycle per accepted, unflushed op. There is no output back-pressure.
- Result is stable between out_valid pulses.

## Structure
- Package alu_pkg holds:
  - the ALUControl codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, MUL 1010, MULHU 1011, DIVU 1100, REMU 1101;
  - the state encoding IDLE/MUL_RUN/DIV_RUN;
  - the ALUOP constants.
- Sub-module alu_ctrl_decode: purely combinational funct/ALUOP → ALUControl, reusable by the main decoder.
- The top level holds the FSM, the iteration counter (log2(WIDTH)+1 bits), the accumulator/remainder registers and the single-cycle ALU.

## Test plan
Benches use WIDTH=32.
- Reset check: assert RST low mid-MUL, then release → Result=0, Zero=1, out_valid=0, in_ready=1 in the first cycle after release.
- R-type SUB: SrcA=5, SrcB=7, ALUOP=10, OP=1, funct7_5=1, funct3=000 → Result=0xFFFFFFFE one cycle later. SLT on the same operands → 1; SLTU with SrcA=0xFFFFFFFF, SrcB=1 → 0.
- Shifts: SRA of 0x80000000 by SrcB=0x24 → shamt 4 → 0xF8000000. SRL of the same → 0x08000000. Back-to-back, out_valid pulses on consecutive cycles.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE exactly 33 cycles after accept. MUL of the same → 0x00000001. in_ready low for 32 cycles.
- Division: DIVU 100/7 → 14 at 33 cycles; REMU 100/7 → 2. DIVU x/0 → 0xFFFFFFFF and REMU 9/0 → 9, each at 1-cycle latency.
- Flush at iteration 10 of DIVU → no out_valid, IDLE next cycle. A request issued with Flush high is ignored. A following ADD 3+4 → 7 at 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU unit.
package alu_pkg;

  // ALUControl codes produced by alu_ctrl_decode.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_MUL   = 4'b1010,
    ALU_MULHU = 4'b1011,
    ALU_DIVU  = 4'b1100,
    ALU_REMU  = 4'b1101
  } alu_ctrl_e;

  // Execute FSM states.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_MUL_RUN = 2'b01,
    S_DIV_RUN = 2'b10
  } alu_state_e;

  // Main-decoder ALUOP classes.
  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
  localparam logic [1:0] ALUOP_ADD_ALT = 2'b11;

  // True for the ops that use the shift-add multiplier.
  function automatic logic is_mul_op(input alu_ctrl_e c);
    return (c == ALU_MUL) || (c == ALU_MULHU);
  endfunction

  // True for the ops that use the restoring divider.
  function automatic logic is_div_op(input alu_ctrl_e c);
    return (c == ALU_DIVU) || (c == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOP/funct -> ALUControl decode, usable outside the execute unit.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       funct7_0_i,
  input  logic       op_i,
  output alu_ctrl_e  alu_ctrl_o
);

  // Map decoder class and instruction fields to an ALUControl code.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD:     alu_ctrl_o = ALU_ADD;
      ALUOP_SUB:     alu_ctrl_o = ALU_SUB;
      ALUOP_ADD_ALT: alu_ctrl_o = ALU_ADD;
      ALUOP_FUNCT: begin
        if (op_i && funct7_0_i) begin
          // M subset: only the unsigned ops are implemented, the rest fall back to ADD.
          case (funct3_i)
            3'b000:  alu_ctrl_o = ALU_MUL;
            3'b011:  alu_ctrl_o = ALU_MULHU;
            3'b101:  alu_ctrl_o = ALU_DIVU;
            3'b111:  alu_ctrl_o = ALU_REMU;
            default: alu_ctrl_o = ALU_ADD;
          endcase
        end else begin
          case (funct3_i)
            3'b000:  alu_ctrl_o = (op_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl_o = ALU_SLL;
            3'b010:  alu_ctrl_o = ALU_SLT;
            3'b011:  alu_ctrl_o = ALU_SLTU;
            3'b100:  alu_ctrl_o = ALU_XOR;
            3'b101:  alu_ctrl_o = funct7_5_i ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ctrl_o = ALU_OR;
            default: alu_ctrl_o = ALU_AND;
          endcase
        end
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage unit: single-cycle ALU plus iterative unsigned multiply/divide.
// Handshake: a request is accepted on a rising edge where in_valid & in_ready & !Flush;
// in_ready is high only in IDLE. out_valid is a one-cycle pulse with no back-pressure.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOP,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             funct7_0,
  input  logic             OP,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             out_valid,
  output logic [1:0]       dbg_state_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  alu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opa_q, opa_d;     // multiplicand or divisor
  alu_ctrl_e          ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               out_valid_q, out_valid_d;

  alu_ctrl_e          dec_ctrl;
  logic [WIDTH-1:0]   alu_y;
  logic [SW-1:0]      shamt;
  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  alu_ctrl_decode u_decode (
    .aluop_i    (ALUOP),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .funct7_0_i (funct7_0),
    .op_i       (OP),
    .alu_ctrl_o (dec_ctrl)
  );

  assign in_ready    = (state_q == S_IDLE);
  assign accept      = in_valid && in_ready && !Flush;
  assign shamt       = SrcB[SW-1:0];
  assign Result      = result_q;
  assign Zero        = (result_q == '0);
  assign out_valid   = out_valid_q;
  assign dbg_state_o = state_q;

  // Single-cycle ALU; also covers divide-by-zero results.
  always_comb begin
    alu_y = '0;
    case (dec_ctrl)
      ALU_ADD:  alu_y = SrcA + SrcB;
      ALU_SUB:  alu_y = SrcA - SrcB;
      ALU_AND:  alu_y = SrcA & SrcB;
      ALU_OR:   alu_y = SrcA | SrcB;
      ALU_XOR:  alu_y = SrcA ^ SrcB;
      ALU_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      ALU_SLL:  alu_y = SrcA << shamt;
      ALU_SRL:  alu_y = SrcA >> shamt;
      ALU_SRA:  alu_y = $signed(SrcA) >>> shamt;
      ALU_DIVU: alu_y = '1;
      ALU_REMU: alu_y = SrcA;
      default:  alu_y = '0;
    endcase
  end

  // One shift-add step (acc = {partial, multiplier}) and one restoring-divide step (acc = {rem, dividend}).
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opa_q});
    // The true remainder is below the divisor, so WIDTH bits are enough.
    div_rem   = div_ge ? (div_trial[WIDTH-1:0] - opa_q) : div_trial[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  // Next-state logic for the FSM and datapath registers; Flush overrides everything but Result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    ctrl_d      = ctrl_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    if (Flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ctrl_d = dec_ctrl;
            cnt_d  = '0;
            if (is_mul_op(dec_ctrl)) begin
              acc_d   = {{WIDTH{1'b0}}, SrcB};
              opa_d   = SrcA;
              state_d = S_MUL_RUN;
            end else if (is_div_op(dec_ctrl) && (SrcB != '0)) begin
              acc_d   = {{WIDTH{1'b0}}, SrcA};
              opa_d   = SrcB;
              state_d = S_DIV_RUN;
            end else begin
              result_d    = alu_y;
              out_valid_d = 1'b1;
            end
          end
        end
        S_MUL_RUN: begin
          acc_d = mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            result_d    = (ctrl_q == ALU_MULHU) ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end
        end
        S_DIV_RUN: begin
          acc_d = div_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            result_d    = (ctrl_q == ALU_REMU) ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opa_q       <= '0;
      ctrl_q      <= ALU_ADD;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opa_q       <= opa_d;
      ctrl_q      <= ctrl_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
